// File: rtl/data_mem_unit.sv
// data_mem_unit: M-stage data memory with byte-lane stores and sign/zero-extended loads.
// Defining DM_RESET_CLEAR_EN adds a post-reset sweep that zeroes every word while busy is high.
module data_mem_unit #(
    parameter int DEPTH = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_m,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  excode_m,
    input  logic        kill,
    output logic [31:0] rdata,
    output logic        busy
);
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_LB    = 6'b100000;
    localparam logic [5:0]  OP_LBU   = 6'b100100;
    localparam logic [5:0]  OP_LH    = 6'b100001;
    localparam logic [5:0]  OP_LHU   = 6'b100101;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_SB    = 6'b101000;
    localparam logic [5:0]  OP_SH    = 6'b101001;
    localparam logic [31:0] ADDR_MAX = 32'(DEPTH * 4 - 1);
    localparam logic [11:0] LAST_IDX = 12'(DEPTH - 1);

    logic [31:0] mem [DEPTH];

    logic [5:0]  opcode;
    logic [11:0] idx;
    logic        in_range;
    logic        is_load;
    logic [3:0]  be;
    logic [31:0] wword;
    logic        clearing;
    logic [11:0] clr_idx;

    assign opcode   = ir_m[31:26];
    assign idx      = addr[13:2];
    assign in_range = (addr <= ADDR_MAX);
    assign is_load  = (opcode == OP_LW)  || (opcode == OP_LB) || (opcode == OP_LBU) ||
                      (opcode == OP_LH)  || (opcode == OP_LHU);

    // Lane select and sign/zero extension for the five load flavours.
    function automatic logic [31:0] load_extend(input logic [5:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic signed [15:0] half;
        logic signed [7:0]  bv;
        half = lane[1] ? word[31:16] : word[15:0];
        bv   = word[8*lane +: 8];
        case (op)
            OP_LW:   return word;
            OP_LH:   return {{16{half[15]}}, half};
            OP_LHU:  return {16'h0000, half};
            OP_LB:   return {{24{bv[7]}}, bv};
            OP_LBU:  return {24'h000000, bv};
            default: return 32'h0000_0000;
        endcase
    endfunction

    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        case (opcode)
            OP_SW: be = 4'b1111;
            OP_SH: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            OP_SB: begin
                be    = 4'b0001 << addr[1:0];
                wword = {4{wdata[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        // Flushed, faulting, out-of-range or sweep-time stores never reach the array.
        if (!in_range || kill || (excode_m != 5'd0) || busy)
            be = 4'b0000;
    end

    always_comb begin
        rdata = 32'h0000_0000;
        if (is_load && in_range && !busy)
            rdata = load_extend(opcode, addr[1:0], mem[idx]);
    end

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_idx] <= 32'h0000_0000;
        end else begin
            for (int n = 0; n < 4; n++)
                if (be[n])
                    mem[idx][8*n +: 8] <= wword[8*n +: 8];
        end
    end

`ifdef DM_RESET_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state;
    logic [11:0] ptr;

    // Reset only arms the sweep; the array itself is zeroed one word per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= 12'd0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + 12'd1;
                    if (ptr == LAST_IDX)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clearing = (state == CLEAR) && !reset;
    assign clr_idx  = ptr;
    assign busy     = (state == CLEAR);
`else
    assign clearing = 1'b0;
    assign clr_idx  = 12'd0;
    assign busy     = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: stores/loads, lane masking, suppression, range and reset sweep.
module tb_data_mem_unit;
    logic        clk;
    logic        reset;
    logic [31:0] ir_m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  excode_m;
    logic        kill;
    logic [31:0] rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef DM_RESET_CLEAR_EN
    localparam int          EXP_SWEEP = 3072;
    localparam logic [31:0] EXP_KEPT  = 32'h0000_0000;
    localparam logic        EXP_BUSY  = 1'b1;
`else
    localparam int          EXP_SWEEP = 0;
    localparam logic [31:0] EXP_KEPT  = 32'h1234_5678;
    localparam logic        EXP_BUSY  = 1'b0;
`endif

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;

    data_mem_unit dut (
        .clk(clk), .reset(reset), .ir_m(ir_m), .addr(addr), .wdata(wdata),
        .excode_m(excode_m), .kill(kill), .rdata(rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic k, input logic [4:0] ex);
        ir_m = {op, 26'd0}; addr = a; wdata = d; kill = k; excode_m = ex;
        tick();
        ir_m = 32'd0; kill = 1'b0; excode_m = 5'd0; wdata = 32'd0;
    endtask

    task automatic load(input logic [5:0] op, input logic [31:0] a);
        ir_m = {op, 26'd0}; addr = a;
        #1;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 5000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== EXP_BUSY) begin errors++; $display("FAIL reset_busy got %b want %b", busy, EXP_BUSY); end
        reset = 1'b0;
        count_busy(cnt);
        checks++;
        if (cnt != EXP_SWEEP) begin errors++; $display("FAIL sweep_len got %0d want %0d", cnt, EXP_SWEEP); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_sweep got %b want 0", busy); end
`ifdef DM_RESET_CLEAR_EN
        load(LW, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL lw_0_cleared got %h want 00000000", rdata); end
`endif
        ir_m = 32'd0; addr = 32'h0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL nonload_rdata got %h want 00000000", rdata); end
    endtask

    task automatic test_word();
        store(SW, 32'h10, 32'h1234_5678, 1'b0, 5'd0);
        load(LW, 32'h10);
        checks++;
        if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL lw_10 got %h want 12345678", rdata); end
        load(LB, 32'h10);
        checks++;
        if (rdata !== 32'h0000_0078) begin errors++; $display("FAIL lb_10 got %h want 00000078", rdata); end
        load(LBU, 32'h13);
        checks++;
        if (rdata !== 32'h0000_0012) begin errors++; $display("FAIL lbu_13 got %h want 00000012", rdata); end
        load(LHU, 32'h10);
        checks++;
        if (rdata !== 32'h0000_5678) begin errors++; $display("FAIL lhu_10 got %h want 00005678", rdata); end
        load(LH, 32'h12);
        checks++;
        if (rdata !== 32'h0000_1234) begin errors++; $display("FAIL lh_12 got %h want 00001234", rdata); end
    endtask

    task automatic test_byte();
        store(SW, 32'h20, 32'h1234_5678, 1'b0, 5'd0);
        store(SB, 32'h21, 32'hAAAA_AA80, 1'b0, 5'd0);
        load(LW, 32'h20);
        checks++;
        if (rdata !== 32'h1234_8078) begin errors++; $display("FAIL sb_lw_20 got %h want 12348078", rdata); end
        load(LB, 32'h21);
        checks++;
        if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_21 got %h want ffffff80", rdata); end
        load(LBU, 32'h21);
        checks++;
        if (rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_21 got %h want 00000080", rdata); end
    endtask

    task automatic test_half_suppress();
        store(SH, 32'h22, 32'h1111_BEEF, 1'b1, 5'd0);
        load(LW, 32'h20);
        checks++;
        if (rdata !== 32'h1234_8078) begin errors++; $display("FAIL sh_kill got %h want 12348078", rdata); end
        store(SH, 32'h22, 32'h1111_BEEF, 1'b0, 5'd5);
        load(LW, 32'h20);
        checks++;
        if (rdata !== 32'h1234_8078) begin errors++; $display("FAIL sh_excode got %h want 12348078", rdata); end
        store(SH, 32'h22, 32'h1111_BEEF, 1'b0, 5'd0);
        load(LW, 32'h20);
        checks++;
        if (rdata !== 32'hBEEF_8078) begin errors++; $display("FAIL sh_lw_20 got %h want beef8078", rdata); end
        load(LH, 32'h22);
        checks++;
        if (rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_22 got %h want ffffbeef", rdata); end
        load(LHU, 32'h22);
        checks++;
        if (rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_22 got %h want 0000beef", rdata); end
        load(LH, 32'h20);
        checks++;
        if (rdata !== 32'hFFFF_8078) begin errors++; $display("FAIL lh_20 got %h want ffff8078", rdata); end
    endtask

    task automatic test_out_of_range();
        store(SW, 32'h2FFC, 32'hA1B2_C3D4, 1'b0, 5'd0);
        store(SW, 32'h7F00, 32'hCAFE_F00D, 1'b0, 5'd0);
        store(SW, 32'h3000, 32'hCAFE_F00D, 1'b0, 5'd0);
        store(SW, 32'h4010, 32'hCAFE_F00D, 1'b0, 5'd0);
        load(LW, 32'h10);
        checks++;
        if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL alias_10 got %h want 12345678", rdata); end
        load(LBU, 32'h2FFF);
        checks++;
        if (rdata !== 32'h0000_00A1) begin errors++; $display("FAIL lbu_2fff got %h want 000000a1", rdata); end
        load(LW, 32'h3000);
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL lw_3000 got %h want 00000000", rdata); end
        load(LW, 32'h4010);
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL lw_4010 got %h want 00000000", rdata); end
    endtask

    task automatic test_back_to_back();
        store(SW, 32'h40, 32'h1111_1111, 1'b0, 5'd0);
        store(SW, 32'h44, 32'h2222_2222, 1'b0, 5'd0);
        store(SB, 32'h47, 32'h0000_0033, 1'b0, 5'd0);
        load(LW, 32'h40);
        checks++;
        if (rdata !== 32'h1111_1111) begin errors++; $display("FAIL b2b_40 got %h want 11111111", rdata); end
        load(LW, 32'h44);
        checks++;
        if (rdata !== 32'h3322_2222) begin errors++; $display("FAIL b2b_44 got %h want 33222222", rdata); end
    endtask

    task automatic test_reset_restart();
        int cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(LW, 32'h10);
        checks++;
        if (rdata !== EXP_KEPT) begin errors++; $display("FAIL rdata_in_sweep got %h want %h", rdata, EXP_KEPT); end
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== EXP_BUSY) begin errors++; $display("FAIL busy_rereset got %b want %b", busy, EXP_BUSY); end
        reset = 1'b0;
        count_busy(cnt);
        checks++;
        if (cnt != EXP_SWEEP) begin errors++; $display("FAIL resweep_len got %0d want %0d", cnt, EXP_SWEEP); end
        load(LW, 32'h10);
        checks++;
        if (rdata !== EXP_KEPT) begin errors++; $display("FAIL lw_10_after got %h want %h", rdata, EXP_KEPT); end
    endtask

    initial begin
        reset = 1'b1; ir_m = 32'd0; addr = 32'd0; wdata = 32'd0; excode_m = 5'd0; kill = 1'b0;
        tick();
        tick();
        test_reset();
        test_word();
        test_byte();
        test_half_suppress();
        test_out_of_range();
        test_back_to_back();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: ir_m  input  32  M-stage instruction; opcode in bits 31:26.
REQ-004 SHALL provide: addr  input  32  M-stage byte address (ALU result).
REQ-005 SHALL provide: wdata  input  32  store data (forwarded rt value).
REQ-006 SHALL provide: excode_m  input  5  M-stage exception code; nonzero blocks the write.
REQ-007 SHALL provide: kill  input  1  interrupt/exception flush in M; 1 blocks the write.
REQ-008 SHALL provide: rdata  output  32  extended load result for the W-stage register.
REQ-009 SHALL provide: busy  output  1  clear sweep in progress; the hazard unit stalls on 1.
REQ-010 SHALL fix parameters: DEPTH = 3072 words, default; byte range 0x0000-0x2FFF.

Function
REQ-011 SHALL decode these opcodes: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001.
REQ-012 SHALL treat an address as in range only when addr <= 0x2FFF; word index = addr[13:2].
REQ-013 SHALL write memory at the posedge when all hold: store opcode, in range, kill=0, excode_m=0, busy=0.
REQ-014 SHALL use little-endian lanes: lane n = bits 8n+7:8n, selected by addr[1:0].
REQ-015 SHALL write on sw all 4 lanes with wdata.
REQ-016 SHALL write on sh lanes {2,3} if addr[1]=1, else lanes {0,1}, using wdata[15:0]; the other lanes are unchanged.
REQ-017 SHALL write on sb the single lane addr[1:0] with wdata[7:0]; the other lanes are unchanged.
REQ-018 SHALL read combinationally (zero latency) from the word at addr[13:2].
REQ-019 SHALL extend loads: lw whole word; lh/lhu select the halfword by addr[1] and sign/zero extend; lb/lbu select the byte by addr[1:0] and sign/zero extend.
REQ-020 SHALL drive rdata = 0 for a non-load opcode, an out-of-range address, or busy=1.
REQ-021 SHALL return, on a read of a word written in the previous cycle, the new value (write-then-read across the edge).
REQ-022 SHALL not write for out-of-range stores (device/bridge space); these have no side effect here.
REQ-023 SHALL not depend on alignment; a misaligned access arrives with nonzero excode_m and is suppressed by REQ-013.

Reset
REQ-024 SHALL drive busy = 1 on reset when DM_RESET_CLEAR_EN is defined, else 0; rdata follows REQ-020.
REQ-025 SHALL restart the sweep at index 0 if reset is asserted mid-sweep.
REQ-026 SHALL leave memory contents untouched by reset itself; only the sweep clears them.

Configuration
REQ-027 SHALL gate the clear sequencer with macro DM_RESET_CLEAR_EN.
REQ-028 SHALL implement, when DM_RESET_CLEAR_EN is defined, states IDLE/CLEAR with a 12-bit ptr:
- reset: state<=CLEAR, ptr<=0.
- CLEAR: mem[ptr]<=0 and ptr++ each cycle; at ptr=3071, write it and go to IDLE.
- busy=1 exactly while in CLEAR: 3072 cycles after reset deasserts.
- Pipeline stores are ignored during CLEAR.
REQ-029 SHALL, when DM_RESET_CLEAR_EN is undefined: no sequencer, busy tied to 0, memory retains contents across reset.

Verification
REQ-030 SHALL cover: macro on, reset 1 cycle -> busy=1 for exactly 3072 cycles, then 0; lw 0x0000 -> 0x00000000.
REQ-031 SHALL cover: sw 0x12345678 @0x10, next cycle lw 0x10 -> 0x12345678; lb 0x10 -> 0x00000078; lbu 0x13 -> 0x00000012.
REQ-032 SHALL cover: sb 0x80 @0x21 over 0x12345678 -> lw 0x20 = 0x12348078; lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080.
REQ-033 SHALL cover: sh 0xBEEF @0x22 with kill=1, then with excode_m=5 -> word unchanged; with both 0 -> lw 0x20 = 0xBEEF8078; lh 0x22 -> 0xFFFFBEEF.
REQ-034 SHALL cover: sw @0x7F00 and @0x3000 -> no memory word changes; lw 0x3000 -> 0x00000000.
REQ-035 SHALL cover: reset again at sweep cycle 100 -> busy stays 1; busy drops 3072 cycles after the second release; earlier-written words read 0.
